// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control FSM and datapath.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef struct packed {
        logic load;
        logic add;
        logic shift;
        logic stop;
    } mult_cmd_t;

    // Iteration counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_result_reg.sv
// Result register with a valid flag cleared by a valid/ready handshake.
module mult_result_reg #(
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_capture,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // Capture wins over a same-cycle handshake so a back-to-back result is never dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_capture) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: executes load/add/shift/stop on {C,A,Q}.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    input  logic               i_load,
    input  logic               i_add,
    input  logic               i_shift,
    input  logic               i_stop,
    output logic               o_lsb,
    output logic               o_last,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    mult_cmd_t cmd;
    assign cmd = '{load: i_load, add: i_add, shift: i_shift, stop: i_stop};

    logic [WIDTH-1:0] m_q, m_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic             at_end;

    assign at_end = (cnt_q == CNT_MAX);

    // Add feeds the shifter directly so add+shift completes one iteration per cycle.
    always_comb begin
        m_d   = m_q;
        c_d   = c_q;
        a_d   = a_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        sum   = {c_q, a_q};
        if (cmd.load) begin
            m_d   = i_multiplicand;
            q_d   = i_multiplier;
            a_d   = '0;
            c_d   = 1'b0;
            cnt_d = '0;
        end else if (!cmd.stop && !at_end) begin
            if (cmd.add) begin
                sum = {1'b0, a_q} + {1'b0, m_q};
            end
            if (cmd.shift) begin
                {c_d, a_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
                cnt_d           = cnt_q + CW'(1);
            end else begin
                {c_d, a_d} = sum;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_q   <= '0;
            c_q   <= 1'b0;
            a_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            c_q   <= c_d;
            a_q   <= a_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    mult_result_reg #(
        .DW (2*WIDTH)
    ) u_result (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (cmd.load),
        .i_capture (cmd.stop && !cmd.load),
        .i_data    ({a_q, q_q}),
        .i_ready   (i_ready),
        .o_data    (o_product),
        .o_valid   (o_valid)
    );

    assign o_lsb  = q_q[0];
    assign o_last = at_end;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: vector table, corner sequences, random vs. model.
module tb_mult_datapath;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   mc, mq;
    logic           ld, add, sh, stp, rdy;
    logic           lsb, last, vld;
    logic [2*W-1:0] prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_datapath #(.WIDTH(W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_multiplicand (mc),
        .i_multiplier   (mq),
        .i_load         (ld),
        .i_add          (add),
        .i_shift        (sh),
        .i_stop         (stp),
        .o_lsb          (lsb),
        .o_last         (last),
        .o_product      (prod),
        .o_valid        (vld),
        .i_ready        (rdy)
    );

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        bit             combined;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld = 0; add = 0; sh = 0; stp = 0;
    endtask

    task automatic do_load(input logic [W-1:0] m, input logic [W-1:0] q);
        mc = m; mq = q; ld = 1;
        cyc();
        ld = 0;
    endtask

    // FSM-style iteration: add when lsb is set, then shift (split or fused).
    task automatic steps(input int k, input bit combined);
        for (int i = 0; i < k; i++) begin
            if (combined) begin
                add = lsb; sh = 1;
                cyc();
                add = 0; sh = 0;
            end else begin
                if (lsb) begin
                    add = 1;
                    cyc();
                    add = 0;
                end
                sh = 1;
                cyc();
                sh = 0;
            end
        end
    endtask

    task automatic do_stop();
        stp = 1;
        cyc();
        stp = 0;
    endtask

    // {A,Q} after k iterations, from arithmetic rather than bit movement.
    function automatic longint partial(input longint m, input longint q, input int k);
        return ((m * (q % (64'd1 << k))) << (W - k)) + (q >> k);
    endfunction

    longint      p_m, m_m, res_m;
    int          cnt_m;
    bit          vld_m;
    int unsigned r;

    initial begin
        rst = 1; rdy = 0; mc = 0; mq = 0;
        idle();
        vecs[0] = '{m: 8'd13,  q: 8'd11,  combined: 1'b0, exp: 16'd143};
        vecs[1] = '{m: 8'd255, q: 8'd255, combined: 1'b0, exp: 16'd65025};
        vecs[2] = '{m: 8'd0,   q: 8'd170, combined: 1'b0, exp: 16'd0};
        vecs[3] = '{m: 8'd170, q: 8'd0,   combined: 1'b1, exp: 16'd0};
        vecs[4] = '{m: 8'd7,   q: 8'd9,   combined: 1'b1, exp: 16'd63};

        cyc(); cyc();
        chk("rst_lsb", lsb, 0);
        chk("rst_last", last, 0);
        chk("rst_prod", prod, 0);
        chk("rst_valid", vld, 0);
        rst = 0;

        foreach (vecs[i]) begin
            do_load(vecs[i].m, vecs[i].q);
            chk("vec_last_after_load", last, 0);
            steps(W, vecs[i].combined);
            chk("vec_last", last, 1);
            chk("vec_valid_before_stop", vld, 0);
            do_stop();
            chk("vec_valid", vld, 1);
            chk("vec_prod", prod, vecs[i].exp);
        end

        // lsb walks through Q bits in order
        do_load(8'd0, 8'd170);
        for (int i = 0; i < W; i++) begin
            chk("lsb_seq", lsb, (170 >> i) & 1);
            sh = 1; cyc(); sh = 0;
        end

        // Shift/add past the WIDTH-th iteration must not disturb state
        do_load(8'd7, 8'd9);
        steps(W, 1'b1);
        add = 1; sh = 1; cyc(); idle();
        chk("sat_last", last, 1);
        do_stop();
        chk("sat_prod", prod, 63);

        // Backpressure, partial capture, and stop coinciding with handshake
        rdy = 1; cyc(); rdy = 0;
        do_load(8'd13, 8'd11);
        steps(4, 1'b0);
        do_stop();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", vld, 1);
            chk("bp_prod_held", prod, partial(13, 11, 4));
        end
        steps(4, 1'b0);
        chk("bp_valid_still", vld, 1);
        rdy = 1; stp = 1; cyc(); stp = 0;
        chk("stop_hs_valid", vld, 1);
        chk("stop_hs_prod", prod, 143);
        cyc();
        chk("hs_valid_clr", vld, 0);
        chk("hs_prod_hold", prod, 143);
        rdy = 0;

        // Reset mid-sequence, then load during reset ignored
        do_load(8'd13, 8'd11);
        steps(3, 1'b1);
        rst = 1; cyc();
        chk("mid_rst_lsb", lsb, 0);
        chk("mid_rst_prod", prod, 0);
        chk("mid_rst_valid", vld, 0);
        mc = 8'd13; mq = 8'd11; ld = 1; cyc();
        chk("rst_load_ign", lsb, 0);
        rst = 0; ld = 0; cyc();
        chk("rst_release_lsb", lsb, 0);
        chk("rst_release_last", last, 0);

        // Random commands against an arithmetic model of {C,A,Q} as one integer
        for (int t = 0; t < 600; t++) begin
            r   = $urandom;
            rst = (t == 0) || (r[5:0] == 0);
            ld  = (r[9:6] == 0);
            stp = (r[12:10] == 0);
            add = r[13];
            sh  = r[14];
            rdy = r[15];
            mc  = W'($urandom);
            mq  = W'($urandom);
            if (rst) begin
                p_m = 0; m_m = 0; cnt_m = 0; res_m = 0; vld_m = 0;
            end else if (ld) begin
                m_m = mc; p_m = mq; cnt_m = 0; vld_m = 0;
            end else if (stp) begin
                res_m = p_m % (64'd1 << (2*W)); vld_m = 1;
            end else begin
                if (vld_m && rdy) vld_m = 0;
                if (cnt_m < W) begin
                    if (add) p_m = ((((p_m >> W) % 256) + m_m) << W) + (p_m % 256);
                    if (sh) begin
                        p_m = p_m >> 1;
                        cnt_m++;
                    end
                end
            end
            cyc();
            chk("rnd_lsb", lsb, p_m % 2);
            chk("rnd_last", last, (cnt_m == W) ? 1 : 0);
            chk("rnd_prod", prod, res_m);
            chk("rnd_valid", vld, vld_m);
        end
        idle(); rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
